// File: rtl/seg_pkg.sv
// Shared types and constants for the segment latch bank.
package seg_pkg;

    localparam int unsigned SEG_NUM_CH_DEF    = 32'd6;
    localparam int unsigned SEG_WIDTH_DEF     = 32'd7;
    localparam int unsigned SEG_BLINK_DIV_DEF = 32'd25_000_000;

    typedef enum logic {
        MODE_DIRECT   = 1'b0,
        MODE_BUFFERED = 1'b1
    } mode_e;

    // All-ones (blank, active-low segments) pattern of the given width.
    function automatic logic [63:0] SEG_BLANK(input int unsigned width);
        SEG_BLANK = (width >= 32'd64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink divider: counts 0..BLINK_DIV-1 and toggles phase on each wrap.
module blink_timer
    import seg_pkg::*;
#(
    parameter int unsigned BLINK_DIV = SEG_BLINK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic phase
);

    localparam int unsigned    CW   = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(BLINK_DIV - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          phase_q;
    logic          phase_d;

    // Next count and phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (cnt_q == LAST) begin
            cnt_d   = {CW{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            phase_d = phase_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= {CW{1'b0}};
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/seg_latch_bank.sv
// Double-buffered seven-segment latch bank with direct/buffered update and per-channel blink.
module seg_latch_bank
    import seg_pkg::*;
#(
    parameter  int unsigned NUM_CH    = SEG_NUM_CH_DEF,
    parameter  int unsigned WIDTH     = SEG_WIDTH_DEF,
    parameter  int unsigned BLINK_DIV = SEG_BLINK_DIV_DEF,
    localparam int unsigned AW        = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 32'd1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mode,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           commit,
    input  logic [NUM_CH-1:0]              blink_en,
    output logic [NUM_CH-1:0][WIDTH-1:0]   out,
    output logic                           pending
);

    localparam logic [WIDTH-1:0] BLANK    = WIDTH'(SEG_BLANK(WIDTH));
    localparam logic [AW:0]      NUM_CH_W = (AW + 1)'(NUM_CH);

    mode_e mode_s;
    logic  wr_ok_s;
    logic  phase_s;
    logic  pending_q;
    logic  pending_d;

    assign mode_s  = mode_e'(mode);
    // Non-power-of-two banks leave addresses that must be dropped entirely.
    assign wr_ok_s = wr_en && ({1'b0, wr_addr} < NUM_CH_W);

    // Pending flag: only meaningful in buffered mode, commit clears with priority.
    always_comb begin
        pending_d = pending_q;
        if (mode_s == MODE_DIRECT) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b0;
        end else if (wr_ok_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Pending register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk   (clk),
        .reset (reset),
        .phase (phase_s)
    );

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             hit_s;
        logic [WIDTH-1:0] shadow_q;
        logic [WIDTH-1:0] shadow_d;
        logic [WIDTH-1:0] disp_q;
        logic [WIDTH-1:0] disp_d;

        assign hit_s = wr_ok_s && (wr_addr == AW'(ch));

        // Shadow/display next state; a write coinciding with commit is published too.
        always_comb begin
            shadow_d = shadow_q;
            disp_d   = disp_q;
            if (hit_s) begin
                shadow_d = wr_data;
            end else begin
                shadow_d = shadow_q;
            end
            if (mode_s == MODE_DIRECT) begin
                if (hit_s) begin
                    disp_d = wr_data;
                end else begin
                    disp_d = disp_q;
                end
            end else if (commit) begin
                disp_d = hit_s ? wr_data : shadow_q;
            end else begin
                disp_d = disp_q;
            end
        end

        // Per-channel storage.
        always_ff @(posedge clk) begin
            if (reset) begin
                shadow_q <= BLANK;
                disp_q   <= BLANK;
            end else begin
                shadow_q <= shadow_d;
                disp_q   <= disp_d;
            end
        end

        assign out[ch] = (blink_en[ch] && phase_s) ? BLANK : disp_q;
    end

endmodule

// File: tb/tb_seg_latch_bank.sv
// Scoreboard bench for seg_latch_bank (NUM_CH=4, WIDTH=7, BLINK_DIV=4) plus a 5-channel instance for address range.
module tb_seg_latch_bank;

    localparam int NC = 4;
    localparam int W  = 7;
    localparam int BD = 4;

    typedef struct {
        logic [NC-1:0][W-1:0] disp;
        logic                 pend;
    } exp_t;

    typedef struct {
        logic [4:0][W-1:0] out;
        logic              pend;
    } exp5_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 mode;
    logic                 wr_en;
    logic [1:0]           wr_addr;
    logic [W-1:0]         wr_data;
    logic                 commit;
    logic [NC-1:0]        blink_en;
    logic [NC-1:0][W-1:0] out;
    logic                 pending;

    logic                 wr_en5;
    logic [2:0]           wr_addr5;
    logic [4:0]           blink_en5;
    logic [4:0][W-1:0]    out5;
    logic                 pending5;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t  exp_q[$];
    exp5_t exp5_q[$];

    logic [NC-1:0][W-1:0] m_shadow;
    logic [NC-1:0][W-1:0] m_disp;
    logic                 m_pend;
    int                   m_cnt   = 0;
    logic                 m_phase = 1'b0;

    seg_latch_bank #(.NUM_CH(NC), .WIDTH(W), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .blink_en(blink_en), .out(out), .pending(pending)
    );

    seg_latch_bank #(.NUM_CH(5), .WIDTH(W), .BLINK_DIV(BD)) dut5 (
        .clk(clk), .reset(reset), .mode(mode), .wr_en(wr_en5), .wr_addr(wr_addr5),
        .wr_data(wr_data), .commit(commit), .blink_en(blink_en5), .out(out5), .pending(pending5)
    );

    // Reference blink phase: half-period of BD cycles from reset.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt   <= 0;
            m_phase <= 1'b0;
        end else if (m_cnt == BD - 1) begin
            m_cnt   <= 0;
            m_phase <= ~m_phase;
        end else begin
            m_cnt   <= m_cnt + 1;
        end
    end

    // Drive one cycle of stimulus, predict the resulting state and push it.
    task automatic step(input logic m, input logic we, input logic [1:0] a,
                        input logic [W-1:0] d, input logic c, input logic r);
        exp_t                 e;
        logic [NC-1:0][W-1:0] sh_old;
        mode = m; wr_en = we; wr_addr = a; wr_data = d; commit = c; reset = r;
        sh_old = m_shadow;
        if (r) begin
            m_shadow = {NC{7'h7F}};
            m_disp   = {NC{7'h7F}};
            m_pend   = 1'b0;
        end else begin
            if (we) m_shadow[a] = d;
            if (!m) begin
                if (we) m_disp[a] = d;
                m_pend = 1'b0;
            end else if (c) begin
                for (int i = 0; i < NC; i++)
                    m_disp[i] = (we && a == 2'(i)) ? d : sh_old[i];
                m_pend = 1'b0;
            end else if (we) begin
                m_pend = 1'b1;
            end
        end
        e.disp = m_disp;
        e.pend = m_pend;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e; logic [NC-1:0][W-1:0] exp_o;
        blink_en = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 2'd0, 7'h00, 1'b0, 1'b1);
            e = exp_q.pop_front();
            for (int ch = 0; ch < NC; ch++) exp_o[ch] = (blink_en[ch] && m_phase) ? 7'h7F : e.disp[ch];
            n_checks++;
            if (out !== exp_o || pending !== e.pend) begin
                n_fail++;
                $display("FAIL reset: out=%h pending=%b expected out=%h pending=%b", out, pending, exp_o, e.pend);
            end
        end
    endtask

    task automatic test_direct();
        exp_t e; logic [NC-1:0][W-1:0] exp_o;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       step(1'b0, 1'b1, 2'd2, 7'h40, 1'b0, 1'b0);
                1:       step(1'b0, 1'b0, 2'd0, 7'h00, 1'b0, 1'b0);
                default: step(1'b0, 1'b0, 2'd1, 7'h00, 1'b1, 1'b0);
            endcase
            e = exp_q.pop_front();
            for (int ch = 0; ch < NC; ch++) exp_o[ch] = (blink_en[ch] && m_phase) ? 7'h7F : e.disp[ch];
            n_checks++;
            if (out !== exp_o || pending !== e.pend) begin
                n_fail++;
                $display("FAIL direct[%0d]: out=%h pending=%b expected out=%h pending=%b", k, out, pending, exp_o, e.pend);
            end
        end
    endtask

    task automatic test_buffered();
        exp_t e; logic [NC-1:0][W-1:0] exp_o;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0:       step(1'b1, 1'b1, 2'd0, 7'h79, 1'b0, 1'b0);
                1:       step(1'b1, 1'b1, 2'd1, 7'h24, 1'b0, 1'b0);
                2:       step(1'b1, 1'b0, 2'd0, 7'h00, 1'b0, 1'b0);
                3:       step(1'b1, 1'b0, 2'd0, 7'h00, 1'b1, 1'b0);
                4:       step(1'b1, 1'b1, 2'd2, 7'h3F, 1'b0, 1'b0);
                5:       step(1'b0, 1'b0, 2'd0, 7'h00, 1'b0, 1'b0);
                default: step(1'b0, 1'b0, 2'd0, 7'h00, 1'b1, 1'b0);
            endcase
            e = exp_q.pop_front();
            for (int ch = 0; ch < NC; ch++) exp_o[ch] = (blink_en[ch] && m_phase) ? 7'h7F : e.disp[ch];
            n_checks++;
            if (out !== exp_o || pending !== e.pend) begin
                n_fail++;
                $display("FAIL buffered[%0d]: out=%h pending=%b expected out=%h pending=%b", k, out, pending, exp_o, e.pend);
            end
        end
    endtask

    task automatic test_write_commit();
        exp_t e; logic [NC-1:0][W-1:0] exp_o;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) step(1'b1, 1'b1, 2'd3, 7'h30, 1'b1, 1'b0);
            else        step(1'b1, 1'b0, 2'd3, 7'h00, 1'b0, 1'b0);
            e = exp_q.pop_front();
            for (int ch = 0; ch < NC; ch++) exp_o[ch] = (blink_en[ch] && m_phase) ? 7'h7F : e.disp[ch];
            n_checks++;
            if (out !== exp_o || pending !== e.pend) begin
                n_fail++;
                $display("FAIL write_commit[%0d]: out=%h pending=%b expected out=%h pending=%b", k, out, pending, exp_o, e.pend);
            end
        end
    endtask

    task automatic test_blink();
        exp_t e; logic [NC-1:0][W-1:0] exp_o;
        step(1'b0, 1'b1, 2'd1, 7'h12, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        blink_en = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, 2'd0, 7'h00, 1'b0, 1'b0);
            e = exp_q.pop_front();
            for (int ch = 0; ch < NC; ch++) exp_o[ch] = (blink_en[ch] && m_phase) ? 7'h7F : e.disp[ch];
            n_checks++;
            if (out !== exp_o || pending !== e.pend) begin
                n_fail++;
                $display("FAIL blink[%0d]: out=%h pending=%b expected out=%h pending=%b", k, out, pending, exp_o, e.pend);
            end
        end
        blink_en = 4'b0000;
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [NC-1:0][W-1:0] exp_o;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       step(1'b1, 1'b1, 2'd0, 7'h55, 1'b0, 1'b0);
                1:       step(1'b1, 1'b1, 2'd2, 7'h0A, 1'b1, 1'b1);
                default: step(1'b1, 1'b0, 2'd0, 7'h00, 1'b1, 1'b0);
            endcase
            e = exp_q.pop_front();
            for (int ch = 0; ch < NC; ch++) exp_o[ch] = (blink_en[ch] && m_phase) ? 7'h7F : e.disp[ch];
            n_checks++;
            if (out !== exp_o || pending !== e.pend) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: out=%h pending=%b expected out=%h pending=%b", k, out, pending, exp_o, e.pend);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [NC-1:0][W-1:0] exp_o;
        for (int k = 0; k < 40; k++) begin
            blink_en = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 7'($urandom_range(0, 127)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
            e = exp_q.pop_front();
            for (int ch = 0; ch < NC; ch++) exp_o[ch] = (blink_en[ch] && m_phase) ? 7'h7F : e.disp[ch];
            n_checks++;
            if (out !== exp_o || pending !== e.pend) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: out=%h pending=%b expected out=%h pending=%b", k, out, pending, exp_o, e.pend);
            end
        end
        blink_en = 4'b0000;
    endtask

    task automatic test_out_of_range();
        exp5_t e;
        wr_en = 1'b0; reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_en5 = 1'b1;
            case (k)
                0: begin
                    mode = 1'b1; wr_addr5 = 3'd5; wr_data = 7'h55; commit = 1'b0;
                    e.out = {5{7'h7F}}; e.pend = 1'b0;
                end
                1: begin
                    mode = 1'b1; wr_addr5 = 3'd7; wr_data = 7'h66; commit = 1'b1;
                    e.out = {5{7'h7F}}; e.pend = 1'b0;
                end
                default: begin
                    mode = 1'b0; wr_addr5 = 3'd4; wr_data = 7'h11; commit = 1'b0;
                    e.out = {7'h11, {4{7'h7F}}}; e.pend = 1'b0;
                end
            endcase
            exp5_q.push_back(e);
            @(posedge clk);
            #1;
            e = exp5_q.pop_front();
            n_checks++;
            if (out5 !== e.out || pending5 !== e.pend) begin
                n_fail++;
                $display("FAIL out_of_range[%0d]: out=%h pending=%b expected out=%h pending=%b", k, out5, pending5, e.out, e.pend);
            end
        end
        wr_en5 = 1'b0; commit = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 7'h00;
        commit = 1'b0; blink_en = 4'b0000;
        wr_en5 = 1'b0; wr_addr5 = 3'd0; blink_en5 = 5'b00000;
        m_shadow = {NC{7'h7F}}; m_disp = {NC{7'h7F}}; m_pend = 1'b0;
        test_reset();
        test_direct();
        test_buffered();
        test_write_commit();
        test_blink();
        test_reset_mid();
        test_back_to_back();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
